// File: rtl/seg_scan_ctrl.sv
// Scan controller for a row of common-anode 7-segment digits that share one
// hex decoder. Each digit is lit for SHOW_CYCLES, then all digits are dark for
// GAP_CYCLES to suppress ghosting. New display data goes into a pending buffer
// and is moved into the active buffer only when the scan wraps to digit 0, so
// a frame always shows one consistent word.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int SHOW_CYCLES = 50000,
  parameter int GAP_CYCLES  = 500
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   data_in,
  input  logic [NUM_DIGITS-1:0]     blank_in,
  output logic                      ready,
  output logic                      load_ack,
  output logic                      frame_start,
  output logic [3:0]                hex_digit,
  output logic [NUM_DIGITS-1:0]     digit_en
);

  // Counter is sized for the longer of the two phases (at least 1 bit).
  localparam int MAX_PHASE = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CNT_W     = $clog2((MAX_PHASE > 2) ? MAX_PHASE : 2);
  localparam int IDX_W     = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(SHOW_CYCLES - 1);
  // With no gap the parked/gap state still lasts one cycle so that the first
  // frame after reset or re-enable starts one cycle later.
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_DIGITS - 1);

  typedef enum logic {
    SHOW = 1'b0,
    GAP  = 1'b1
  } state_t;

  // Scan state
  state_t                    state_reg,  state_next;
  logic [CNT_W-1:0]          cnt_reg,    cnt_next;
  logic [IDX_W-1:0]          idx_reg,    idx_next;
  logic                      advance;
  logic                      boundary;

  // Display buffers and handshake
  logic [4*NUM_DIGITS-1:0]   act_data_reg,   act_data_next;
  logic [NUM_DIGITS-1:0]     act_blank_reg,  act_blank_next;
  logic [4*NUM_DIGITS-1:0]   pend_data_reg,  pend_data_next;
  logic [NUM_DIGITS-1:0]     pend_blank_reg, pend_blank_next;
  logic                      pend_valid_reg, pend_valid_next;
  logic                      accept;
  logic                      commit;

  // Registered outputs
  logic                      ready_reg;
  logic                      load_ack_reg;
  logic                      frame_start_reg;
  logic [3:0]                hex_digit_reg,  hex_digit_next;
  logic [NUM_DIGITS-1:0]     digit_en_reg,   digit_en_next;

  // Decode helpers for the digit that will be current next cycle
  logic [NUM_DIGITS-1:0]     digit_hit;
  logic [3:0]                hex_sel;
  logic                      blank_sel;

  // Scan sequencing: count through SHOW and GAP, step the digit index, and
  // park in GAP at the last digit whenever the scan is disabled.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CNT_W'(1);
    idx_next   = idx_reg;
    advance    = 1'b0;
    if (!enable) begin
      state_next = GAP;
      cnt_next   = '0;
      idx_next   = LAST_IDX;
    end else begin
      case (state_reg)
        SHOW: begin
          if (cnt_reg == SHOW_LAST) begin
            cnt_next = '0;
            if (GAP_CYCLES == 0) begin
              advance = 1'b1;
            end else begin
              state_next = GAP;
            end
          end
        end
        default: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_next = '0;
            advance  = 1'b1;
          end
        end
      endcase
      if (advance) begin
        state_next = SHOW;
        idx_next   = (idx_reg == LAST_IDX) ? '0 : idx_reg + IDX_W'(1);
      end
    end
    boundary = advance && (idx_next == '0);
  end

  // Pending/active buffer management: accept into pending when it is empty,
  // move pending to active only at a frame boundary.
  always_comb begin
    accept          = load && !pend_valid_reg;
    commit          = boundary && pend_valid_reg;
    pend_data_next  = pend_data_reg;
    pend_blank_next = pend_blank_reg;
    pend_valid_next = pend_valid_reg;
    act_data_next   = act_data_reg;
    act_blank_next  = act_blank_reg;
    if (accept) begin
      pend_data_next  = data_in;
      pend_blank_next = blank_in;
      pend_valid_next = 1'b1;
    end else if (commit) begin
      act_data_next   = pend_data_reg;
      act_blank_next  = pend_blank_reg;
      pend_valid_next = 1'b0;
    end
  end

  // One-hot select of the next digit, used for both enable and nibble mux.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit_hit
      assign digit_hit[gi] = (idx_next == IDX_W'(gi));
    end
  endgenerate

  // Output decode from next-cycle state so the outputs can be registered
  // without adding a cycle of latency.
  always_comb begin
    hex_sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_hit[i]) begin
        hex_sel = act_data_next[4*i +: 4];
      end
    end
    blank_sel = |(digit_hit & act_blank_next);
    if (state_next == SHOW) begin
      hex_digit_next = hex_sel;
      digit_en_next  = blank_sel ? '1 : ~digit_hit;
    end else begin
      hex_digit_next = hex_digit_reg;
      digit_en_next  = '1;
    end
  end

  // Scan FSM, buffers and registered outputs. Reset darkens the display
  // immediately and drops both buffers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= GAP;
      cnt_reg         <= '0;
      idx_reg         <= LAST_IDX;
      act_data_reg    <= '0;
      act_blank_reg   <= '1;
      pend_data_reg   <= '0;
      pend_blank_reg  <= '0;
      pend_valid_reg  <= 1'b0;
      ready_reg       <= 1'b1;
      load_ack_reg    <= 1'b0;
      frame_start_reg <= 1'b0;
      hex_digit_reg   <= '0;
      digit_en_reg    <= '1;
    end else begin
      state_reg       <= state_next;
      cnt_reg         <= cnt_next;
      idx_reg         <= idx_next;
      act_data_reg    <= act_data_next;
      act_blank_reg   <= act_blank_next;
      pend_data_reg   <= pend_data_next;
      pend_blank_reg  <= pend_blank_next;
      pend_valid_reg  <= pend_valid_next;
      ready_reg       <= ~pend_valid_next;
      load_ack_reg    <= commit;
      frame_start_reg <= boundary;
      hex_digit_reg   <= hex_digit_next;
      digit_en_reg    <= digit_en_next;
    end
  end

  assign ready       = ready_reg;
  assign load_ack    = load_ack_reg;
  assign frame_start = frame_start_reg;
  assign hex_digit   = hex_digit_reg;
  assign digit_en    = digit_en_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a timeline model derived from frame arithmetic is
// compared every cycle against the main instance (gap = 2), and literal
// expectations pin key cycles on it and on a second, gapless instance.
module tb_seg_scan_ctrl;
  localparam int N     = 4;
  localparam int S     = 4;
  localparam int G     = 2;
  localparam int PER   = S + G;
  localparam int FRAME = N * PER;
  localparam int LEAD  = (G == 0) ? 1 : G;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        enable   = 1'b0;
  logic        load     = 1'b0;
  logic [15:0] data_in  = 16'h0;
  logic [3:0]  blank_in = 4'h0;

  logic        a_ready, a_ack, a_fs;
  logic [3:0]  a_hex, a_en;
  logic        b_ready, b_ack, b_fs;
  logic [3:0]  b_hex, b_en;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Timeline model state
  int          m_t;
  logic        m_pend_valid;
  logic [15:0] m_pend_data, m_act_data;
  logic [3:0]  m_pend_blank, m_act_blank;
  logic        m_ack, m_fs;
  logic [3:0]  m_hex, m_en;

  seg_scan_ctrl #(.NUM_DIGITS(N), .SHOW_CYCLES(S), .GAP_CYCLES(G)) dut_a (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .data_in(data_in), .blank_in(blank_in),
    .ready(a_ready), .load_ack(a_ack), .frame_start(a_fs),
    .hex_digit(a_hex), .digit_en(a_en)
  );

  seg_scan_ctrl #(.NUM_DIGITS(N), .SHOW_CYCLES(S), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .enable(enable), .load(load),
    .data_in(data_in), .blank_in(blank_in),
    .ready(b_ready), .load_ack(b_ack), .frame_start(b_fs),
    .hex_digit(b_hex), .digit_en(b_en)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d t=%0t: got %b, expected %b", name, cyc, $time, act, exp);
    end
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d t=%0t: got %b, expected %b", name, cyc, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_t          = 0;
    m_pend_valid = 1'b0;
    m_pend_data  = 16'h0;
    m_pend_blank = 4'h0;
    m_act_data   = 16'h0;
    m_act_blank  = 4'hF;
    m_ack        = 1'b0;
    m_fs         = 1'b0;
    m_hex        = 4'h0;
    m_en         = 4'hF;
  endtask

  // t counts enabled cycles since the last park; position in the frame is
  // plain arithmetic on t.
  task automatic model_step();
    int   tn, p, d, w;
    logic was_pending;
    was_pending = m_pend_valid;
    tn    = enable ? m_t + 1 : 0;
    m_ack = 1'b0;
    m_fs  = 1'b0;
    if (tn >= LEAD && ((tn - LEAD) % FRAME) == 0) begin
      m_fs = 1'b1;
      if (was_pending) begin
        m_act_data   = m_pend_data;
        m_act_blank  = m_pend_blank;
        m_pend_valid = 1'b0;
        m_ack        = 1'b1;
      end
    end
    if (load && !was_pending) begin
      m_pend_data  = data_in;
      m_pend_blank = blank_in;
      m_pend_valid = 1'b1;
    end
    m_t  = tn;
    m_en = 4'hF;
    if (tn >= LEAD) begin
      p = (tn - LEAD) % FRAME;
      d = p / PER;
      w = p % PER;
      if (w < S) begin
        m_hex = 4'((m_act_data >> (4 * d)) & 16'hF);
        if (!m_act_blank[d]) m_en = ~(4'(1) << d);
      end
    end
  endtask

  // Model advance on each clock edge; async reset clears it at once.
  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      chk1("ready",       a_ready, ~m_pend_valid);
      chk1("load_ack",    a_ack,   m_ack);
      chk1("frame_start", a_fs,    m_fs);
      chk4("hex_digit",   a_hex,   m_hex);
      chk4("digit_en",    a_en,    m_en);
      chk1("one_lit_max", ($countones(~a_en) <= 1), 1'b1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_to(input int k);
    while (cyc < k) tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] b);
    load     = 1'b1;
    data_in  = d;
    blank_in = b;
    $display("load cyc=%0d data=%h blank=%b ready=%0b", cyc, d, b, a_ready);
    tick();
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst_n  = 1'b1;
    enable = 1'b1;
    cyc    = 0;
    chk1("rst_ready", a_ready, 1'b1);
    chk4("rst_en",    a_en,    4'b1111);
    chk4("rst_hex",   a_hex,   4'h0);
    chk1("rst_fs",    a_fs,    1'b0);
    chk1("rst_ack",   a_ack,   1'b0);

    // First frame commits the word loaded in cycle 0
    do_load(16'h3A7C, 4'b0000);
    chk1("ready_c1", a_ready, 1'b0);
    chk1("b_fs_c1",  b_fs,    1'b1);
    chk1("b_ack_c1", b_ack,   1'b0);
    chk4("b_en_c1",  b_en,    4'b1111);
    run_to(2);
    chk1("ack_c2", a_ack, 1'b1);
    chk1("fs_c2",  a_fs,  1'b1);
    chk4("en_c2",  a_en,  4'b1110);
    chk4("hex_c2", a_hex, 4'hC);
    run_to(5);  chk4("en_c5",  a_en,  4'b1110);
    run_to(6);  chk4("en_c6",  a_en,  4'b1111); chk4("hex_c6", a_hex, 4'hC);
    run_to(8);  chk4("en_c8",  a_en,  4'b1101); chk4("hex_c8", a_hex, 4'h7);
    run_to(14); chk4("en_c14", a_en,  4'b1011); chk4("hex_c14", a_hex, 4'hA);
    run_to(17);
    chk1("b_fs_c17",  b_fs,  1'b1);
    chk1("b_ack_c17", b_ack, 1'b1);
    chk4("b_en_c17",  b_en,  4'b1110);
    chk4("b_hex_c17", b_hex, 4'hC);
    run_to(20);
    chk4("en_c20",   a_en,  4'b0111);
    chk4("hex_c20",  a_hex, 4'h3);
    chk4("b_en_c20", b_en,  4'b1110);
    run_to(21); chk4("b_en_c21", b_en, 4'b1101); chk4("b_hex_c21", b_hex, 4'h7);
    run_to(25); chk1("fs_c25", a_fs, 1'b0);
    run_to(26); chk1("fs_c26", a_fs, 1'b1); chk1("ack_c26", a_ack, 1'b0);

    // Two loads in one frame: the second arrives on the boundary cycle
    run_to(30);
    do_load(16'h1111, 4'b0000);
    chk1("ready_c31", a_ready, 1'b0);
    run_to(49);
    do_load(16'h2222, 4'b0000);
    chk1("ack_c50",   a_ack,   1'b1);
    chk1("fs_c50",    a_fs,    1'b1);
    chk4("hex_c50",   a_hex,   4'h1);
    chk1("ready_c50", a_ready, 1'b1);
    run_to(56); chk4("en_c56", a_en, 4'b1101); chk4("hex_c56", a_hex, 4'h1);
    run_to(74); chk1("fs_c74", a_fs, 1'b1); chk1("ack_c74", a_ack, 1'b0); chk4("hex_c74", a_hex, 4'h1);

    // Blanked digits 0 and 2
    run_to(76);
    do_load(16'h5678, 4'b0101);
    run_to(98);
    chk1("ack_c98", a_ack, 1'b1);
    chk4("en_c98",  a_en,  4'b1111);
    chk4("hex_c98", a_hex, 4'h8);
    run_to(100);
    do_load(16'h9ABC, 4'b0000);
    run_to(104); chk4("en_c104", a_en, 4'b1101); chk4("hex_c104", a_hex, 4'h7);
    run_to(110); chk4("en_c110", a_en, 4'b1111);
    run_to(116); chk4("en_c116", a_en, 4'b0111); chk4("hex_c116", a_hex, 4'h5);
    run_to(122);
    chk1("fs_c122",  a_fs,  1'b1);
    chk1("ack_c122", a_ack, 1'b1);
    chk4("en_c122",  a_en,  4'b1110);

    // Enable drop during digit 2 with data pending
    run_to(126);
    do_load(16'hDEF0, 4'b0000);
    run_to(135);
    chk4("en_c135", a_en, 4'b1011);
    chk4("hex_c135", a_hex, 4'hA);
    enable = 1'b0;
    tick();
    chk4("en_c136",  a_en,  4'b1111);
    chk4("hex_c136", a_hex, 4'hA);
    run_to(140);
    chk1("ready_c140", a_ready, 1'b0);
    enable = 1'b1;
    run_to(141); chk4("en_c141", a_en, 4'b1111);
    run_to(142);
    chk1("fs_c142",  a_fs,  1'b1);
    chk1("ack_c142", a_ack, 1'b1);
    chk4("en_c142",  a_en,  4'b1110);
    chk4("hex_c142", a_hex, 4'h0);

    // Reset mid-frame with data pending
    run_to(150);
    do_load(16'h1234, 4'b0000);
    run_to(155);
    chk4("en_c155",  a_en,  4'b1011);
    chk4("hex_c155", a_hex, 4'hE);
    chk1("ready_c155", a_ready, 1'b0);
    rst_n = 1'b0;
    #1;
    chk4("arst_en",    a_en,    4'b1111);
    chk4("arst_hex",   a_hex,   4'h0);
    chk1("arst_ready", a_ready, 1'b1);
    chk1("arst_ack",   a_ack,   1'b0);
    chk1("arst_fs",    a_fs,    1'b0);
    chk4("b_arst_en",  b_en,    4'b1111);
    chk1("b_arst_rdy", b_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc   = 0;
    run_to(2);
    chk1("post_fs_c2",  a_fs,  1'b1);
    chk1("post_ack_c2", a_ack, 1'b0);
    chk4("post_en_c2",  a_en,  4'b1111);
    run_to(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
